lut_layer_scheduler: RTL

Time-multiplexed evaluator for one LogicNets layer of LUT neurons. All neurons share a single programmable truth-table RAM instead of each having its own hard-coded ROM. The block accepts a packed layer input vector with a valid/ready handshake and evaluates the neurons one per cycle. It then presents the packed layer output, also under valid/ready. Truth tables are written through a configuration port while the block is idle.

---
 rtl/lut_layer_scheduler.sv | 118 +++++++++++
 1 files changed

// File: rtl/lut_layer_scheduler.sv
// Time-multiplexed LogicNets layer: every neuron shares one truth-table RAM and
// is evaluated one per cycle; results are packed and handed off under valid/ready.
module lut_layer_scheduler #(
  parameter  int IN_BITS     = 8,
  parameter  int OUT_BITS    = 2,
  parameter  int NUM_NEURONS = 4,
  localparam int CNT_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_NEURONS*IN_BITS-1:0]  in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_NEURONS*OUT_BITS-1:0] out_data,
  input  logic                            cfg_we,
  input  logic [CNT_W+IN_BITS-1:0]        cfg_addr,
  input  logic [OUT_BITS-1:0]             cfg_data,
  output logic                            cfg_err,
  output logic                            busy
);

  localparam int ADDR_W = CNT_W + IN_BITS;
  localparam int DEPTH  = NUM_NEURONS << IN_BITS;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HOLD} state_t;

  state_t                          r_state, w_state_next;
  logic [NUM_NEURONS*IN_BITS-1:0]  r_in_data;
  logic [CNT_W-1:0]                r_idx, r_idx_prev;
  logic                            r_rd_vld;
  logic [OUT_BITS-1:0]             r_rd_data;
  logic [OUT_BITS-1:0]             r_slot [NUM_NEURONS];
  logic [NUM_NEURONS*OUT_BITS-1:0] r_out_data;
  logic [OUT_BITS-1:0]             r_mem  [DEPTH];

  logic [IN_BITS-1:0]              w_in_slice [NUM_NEURONS];
  logic [ADDR_W-1:0]               w_rd_addr;
  logic                            w_last_idx;
  logic                            w_accept;
  logic                            w_cfg_in_range;
  logic                            w_cfg_wr;

  for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_slice
    assign w_in_slice[g] = r_in_data[g*IN_BITS +: IN_BITS];
  end

  assign w_rd_addr      = {r_idx, w_in_slice[r_idx]};
  assign w_last_idx     = (r_idx == CNT_W'(NUM_NEURONS - 1));
  assign w_accept       = (r_state == S_IDLE) && in_valid;
  assign w_cfg_in_range = (32'(cfg_addr[ADDR_W-1:IN_BITS]) < 32'(NUM_NEURONS));
  // A simultaneous input vector wins over a table write in IDLE.
  assign w_cfg_wr       = cfg_we && (r_state == S_IDLE) && !in_valid && w_cfg_in_range;
  assign out_data       = r_out_data;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so every path drives the signal and no latch is inferred.
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (in_valid)   w_state_next = S_RUN;
      S_RUN:   if (w_last_idx) w_state_next = S_DRAIN;
      S_DRAIN:                 w_state_next = S_HOLD;
      S_HOLD:  if (out_ready)  w_state_next = S_IDLE;
      default:                 w_state_next = S_IDLE;
    endcase
  end

  // Outputs; in_ready and cfg_err are held low while rst is asserted.
  always_comb begin
    in_ready  = (r_state == S_IDLE) && !rst;
    busy      = (r_state != S_IDLE);
    out_valid = (r_state == S_HOLD);
    cfg_err   = cfg_we && !w_cfg_wr && !rst;
  end

  // NOTE: table RAM has no reset; its contents must survive rst and it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_cfg_wr) r_mem[cfg_addr] <= cfg_data;
    r_rd_data <= r_mem[w_rd_addr];
  end

  // Datapath: read data lands one cycle after its address, tagged by r_idx_prev.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state is always updated with non-blocking assignments.
      r_in_data  <= '0;
      r_idx      <= '0;
      r_idx_prev <= '0;
      r_rd_vld   <= 1'b0;
      r_out_data <= '0;
      for (int n = 0; n < NUM_NEURONS; n++) r_slot[n] <= '0;
    end else begin
      if (w_accept) begin
        r_in_data <= in_data;
        r_idx     <= '0;
      end else if (r_state == S_RUN) begin
        r_idx <= w_last_idx ? '0 : r_idx + 1'b1;
      end
      r_rd_vld   <= (r_state == S_RUN);
      r_idx_prev <= r_idx;
      if (r_rd_vld) r_slot[r_idx_prev] <= r_rd_data;
      // The last neuron's data is merged straight from the RAM output.
      if (r_state == S_DRAIN) begin
        for (int n = 0; n < NUM_NEURONS; n++)
          r_out_data[n*OUT_BITS +: OUT_BITS] <= (r_idx_prev == CNT_W'(n)) ? r_rd_data : r_slot[n];
      end
    end
  end

endmodule
